rand_arbiter: RTL and testbench
===============================

RAND_ARBITER -- requirements
Module: rand_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one rand8bit LFSR.
REQ-002 Parameter STEPS, default 8: LFSR advances per draw, range 1..15.
REQ-003 Parameter MAX_TRIES, default 4: rejection-sampling attempts before fallback, range 1..15.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 req  input  NREQ  per-requester draw request; level, held until gnt.
REQ-007 range_max  input  8  inclusive upper bound for the drawn value.
REQ-008 lfsr_out  input  8  current rand8bit output.
REQ-009 lfsr_enable  output  1  rand8bit enable.
REQ-010 lfsr_reset  output  1  rand8bit reset; OR-ed with system reset externally.
REQ-011 gnt  output  NREQ  one-hot grant, single-cycle pulse.
REQ-012 rnd_valid  output  1  high exactly when gnt is non-zero.
REQ-013 rnd_data  output  8  drawn value; valid only when rnd_valid is high.

Function
REQ-014 FSM states SHALL be IDLE, STEP, CHECK and GRANT.
REQ-015 IDLE with req != 0: round-robin winner search starting at index last+1 mod NREQ; latch winner, range_max and mask; step counter = STEPS; tries = 0; go to STEP.
REQ-016 mask = smallest all-ones value (2^k - 1) that is >= range_max; range_max = 0 gives mask 0.
REQ-017 STEP: lfsr_enable = 1 every cycle; decrement counter; go to CHECK on the cycle the counter reaches 0.
REQ-018 CHECK, lfsr_out == 8'hFF (XNOR lockup): lfsr_reset = 1 for one cycle; counter = 1; return to STEP; tries unchanged.
REQ-019 CHECK, v = lfsr_out & mask <= latched range_max: rnd_data <= v; go to GRANT.
REQ-020 CHECK, v > range_max and tries < MAX_TRIES-1: tries++; counter = 1; return to STEP.
REQ-021 CHECK, v > range_max and tries == MAX_TRIES-1: rnd_data <= v - (range_max+1), 8-bit; go to GRANT. This value is always <= range_max.
REQ-022 GRANT: gnt[winner] = 1 and rnd_valid = 1 for exactly one cycle; last <= winner; next state IDLE.
REQ-023 Best-case latency: gnt asserts STEPS+2 cycles after the IDLE cycle that samples req, i.e. 10 cycles at defaults.
REQ-024 Requests are non-preemptive: req changes during service do not alter the winner.
REQ-025 If the winner drops req mid-service, the draw still completes and gnt still pulses.
REQ-026 range_max changes after the IDLE sample have no effect on the draw in progress.
REQ-027 Back-to-back service: IDLE lasts one cycle between grants; with all req held, grants rotate 0,1,2,3,0.
REQ-028 lfsr_enable and lfsr_reset SHALL never be high in the same cycle; both are 0 in IDLE and GRANT.

Reset
REQ-029 Reset SHALL apply on any cycle, including mid-draw: state = IDLE, gnt = 0, rnd_valid = 0, rnd_data = 0, lfsr_enable = 0, lfsr_reset = 0, tries = 0, counter = 0.
REQ-030 Reset SHALL set last = NREQ-1, so requester 0 has first priority.
REQ-031 A req asserted during reset is first sampled on the first IDLE cycle after reset deasserts.

Verification
REQ-032 Bench SHALL pair the block with rand8bit (XNOR taps 7,3, resets to 0); defaults unless stated.
REQ-033 Reset; req = 0001, range_max = FF -> gnt = 0001 at cycle 10, rnd_data = F0 (sequence 01,03,07,0F,1E,3C,78,F0).
REQ-034 As REQ-033 but range_max = 0F -> mask 0F, rnd_data = 00, no retry.
REQ-035 req = 1111 held for four grants -> gnt order 0001, 0010, 0100, 1000; exactly one-cycle pulses; rnd_valid coincident with gnt.
REQ-036 Force lfsr_out = FF at CHECK -> one-cycle lfsr_reset, one further STEP cycle, no gnt that cycle.
REQ-037 range_max = 00 -> every grant has rnd_data = 00; assert reset during a STEP -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/rand_arbiter.sv
// Round-robin arbiter that serves each grant with a bounded random draw from a shared
// external 8-bit LFSR, using masked rejection sampling with a subtract fallback.
module rand_arbiter #(
    parameter int NREQ      = 4,
    parameter int STEPS     = 8,
    parameter int MAX_TRIES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [7:0]      range_max,
    input  logic [7:0]      lfsr_out,
    output logic            lfsr_enable,
    output logic            lfsr_reset,
    output logic [NREQ-1:0] gnt,
    output logic            rnd_valid,
    output logic [7:0]      rnd_data
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {Idle, Step, Check, Grant} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] winner_q, winner_d;
    logic [IW-1:0] last_q, last_d;
    logic [7:0]    rmax_q, rmax_d;
    logic [7:0]    mask_q, mask_d;
    logic [7:0]    data_q, data_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    tries_q, tries_d;

    logic [7:0]    smear;
    logic [7:0]    val;
    logic [IW-1:0] cand;
    logic          found;

    // Smearing the top set bit downwards yields the smallest 2^k-1 covering range_max.
    always_comb begin
        smear = range_max | (range_max >> 1);
        smear = smear | (smear >> 2);
        smear = smear | (smear >> 4);
    end

    assign val      = lfsr_out & mask_q;
    assign rnd_data = data_q;

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        last_d      = last_q;
        rmax_d      = rmax_q;
        mask_d      = mask_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        tries_d     = tries_q;
        lfsr_enable = 1'b0;
        lfsr_reset  = 1'b0;
        gnt         = '0;
        rnd_valid   = 1'b0;
        found       = 1'b0;
        cand        = '0;

        unique case (state_q)
            Idle: begin
                if (|req) begin
                    for (int i = 0; i < NREQ; i++) begin
                        cand = IW'((int'(last_q) + 1 + i) % NREQ);
                        if (!found && req[cand]) begin
                            found    = 1'b1;
                            winner_d = cand;
                        end
                    end
                    rmax_d  = range_max;
                    mask_d  = smear;
                    cnt_d   = 4'(STEPS);
                    tries_d = '0;
                    state_d = Step;
                end
            end
            Step: begin
                lfsr_enable = 1'b1;
                cnt_d       = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = Check;
                end
            end
            Check: begin
                if (lfsr_out == 8'hFF) begin
                    // XNOR LFSR lockup: restart it and take one more step.
                    lfsr_reset = 1'b1;
                    cnt_d      = 4'd1;
                    state_d    = Step;
                end else if (val <= rmax_q) begin
                    data_d  = val;
                    state_d = Grant;
                end else if (tries_q < 4'(MAX_TRIES - 1)) begin
                    tries_d = tries_q + 4'd1;
                    cnt_d   = 4'd1;
                    state_d = Step;
                end else begin
                    data_d  = val - rmax_q - 8'd1;
                    state_d = Grant;
                end
            end
            Grant: begin
                gnt[winner_q] = 1'b1;
                rnd_valid     = 1'b1;
                last_d        = winner_q;
                state_d       = Idle;
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= Idle;
            winner_q <= '0;
            last_q   <= IW'(NREQ - 1);
            rmax_q   <= '0;
            mask_q   <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            tries_q  <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            rmax_q   <= rmax_d;
            mask_q   <= mask_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            tries_q  <= tries_d;
        end
    end

endmodule

// File: tb/tb_rand_arbiter.sv
// Bench for rand_arbiter paired with a rand8bit-style XNOR LFSR (taps 7,3);
// predicted grants and values are queued at stimulus time and popped at each grant.
module tb_rand_arbiter;

    localparam int NREQ      = 4;
    localparam int STEPS     = 8;
    localparam int MAX_TRIES = 4;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [7:0] range_max = '0;
    logic [7:0] lfsr_out;
    logic [7:0] lfsr_q;
    logic       lfsr_enable, lfsr_reset, rnd_valid;
    logic [3:0] gnt;
    logic [7:0] rnd_data;
    logic       force_en = 1'b0;
    logic [7:0] force_val = '0;

    int         n_vec = 0;
    int         n_miss = 0;
    exp_t       sb_q[$];
    logic [7:0] model_lfsr;
    int         model_last;
    logic [7:0] last_data = '0;
    logic [3:0] prev_gnt = '0;

    rand_arbiter #(
        .NREQ     (NREQ),
        .STEPS    (STEPS),
        .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .range_max  (range_max),
        .lfsr_out   (lfsr_out),
        .lfsr_enable(lfsr_enable),
        .lfsr_reset (lfsr_reset),
        .gnt        (gnt),
        .rnd_valid  (rnd_valid),
        .rnd_data   (rnd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] adv(input logic [7:0] s);
        return {s[6:0], ~(s[7] ^ s[3])};
    endfunction

    // rand8bit stand-in; the override lets the bench present arbitrary values at CHECK.
    assign lfsr_out = force_en ? force_val : lfsr_q;
    always @(posedge clk) begin
        if (reset || lfsr_reset) lfsr_q <= '0;
        else if (lfsr_enable)    lfsr_q <= adv(lfsr_q);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r);
        for (int i = 1; i <= NREQ; i++) begin
            int idx = (model_last + i) % NREQ;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    // Draw model: cycle count from the IDLE sample to the grant, and the drawn value.
    task automatic model_draw(input logic [7:0] rmax, input bit fen, input logic [7:0] fv,
                              output logic [7:0] val, output int lat);
        logic [7:0] mask = '0;
        logic [7:0] s, c, v;
        int         tries = 0;
        while (mask < rmax) mask = {mask[6:0], 1'b1};
        s   = model_lfsr;
        lat = 0;
        val = '0;
        for (int i = 0; i < STEPS; i++) begin
            s = adv(s);
            lat++;
        end
        forever begin
            lat++;
            c = fen ? fv : s;
            if (c == 8'hFF) begin
                s = adv(8'h00);
                lat++;
                continue;
            end
            v = c & mask;
            if (v <= rmax) begin
                val = v;
                break;
            end
            if (tries < MAX_TRIES - 1) begin
                tries++;
                s = adv(s);
                lat++;
            end else begin
                val = v - rmax - 8'd1;
                break;
            end
        end
        lat++;
        model_lfsr = s;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (prev_gnt != 0) check("gnt_pulse", gnt, 0);
            if (lfsr_reset) check("en_rst_excl", lfsr_enable, 0);
            if (rnd_valid || gnt != 0) begin
                check("valid_eq_gnt", rnd_valid, gnt != 0);
                if (sb_q.size() == 0) begin
                    check("unexpected_gnt", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    check("gnt", gnt, e.gnt);
                    check("data", rnd_data, e.data);
                end
                last_data = rnd_data;
            end
        end
        prev_gnt = reset ? 4'd0 : gnt;
    end

    task automatic do_reset();
        reset    = 1'b1;
        req      = '0;
        force_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_valid", rnd_valid, 0);
        check("rst_data", rnd_data, 0);
        check("rst_en", lfsr_enable, 0);
        check("rst_lrst", lfsr_reset, 0);
        reset      = 1'b0;
        model_lfsr = '0;
        model_last = NREQ - 1;
        sb_q.delete();
    endtask

    task automatic serve(input logic [3:0] r, input logic [7:0] rmax, input int n,
                         input bit perturb, input bit fen, input logic [7:0] fv);
        int         lat, lat0 = 0, cyc = 0, got = 0, w;
        logic [7:0] val;
        exp_t       e;
        for (int k = 0; k < n; k++) begin
            w = rr_pick(r);
            model_draw(rmax, fen, fv, val, lat);
            if (k == 0) lat0 = lat;
            e.gnt  = 4'b0001 << w;
            e.data = val;
            sb_q.push_back(e);
            model_last = w;
        end
        req       = r;
        range_max = rmax;
        force_en  = fen;
        force_val = fv;
        while (got < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (perturb && cyc == 3) begin
                req       = ~r;
                range_max = ~rmax;
            end
            if (rnd_valid) begin
                got++;
                if (got == 1) check("latency", cyc, lat0);
                if (got == n) begin
                    req      = '0;
                    force_en = 1'b0;
                end
            end
        end
        if (got < n) check("timeout", got, n);
        req      = '0;
        force_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, n_miss=%0d", n_miss);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        do_reset();
        serve(4'b0001, 8'hFF, 1, 0, 0, 8'h00);
        check("first_draw_f0", last_data, 8'hF0);

        do_reset();
        serve(4'b0001, 8'h0F, 1, 0, 0, 8'h00);
        check("masked_draw_00", last_data, 8'h00);

        do_reset();
        serve(4'b1111, 8'hFF, 4, 0, 0, 8'h00);
        serve(4'b1111, 8'h00, 4, 0, 0, 8'h00);
        serve(4'b0010, 8'h80, 1, 1, 0, 8'h00);
        serve(4'b0001, 8'h50, 1, 0, 0, 8'h00);
        serve(4'b0100, 8'h50, 1, 0, 1, 8'hFE);
        check("fallback_2d", last_data, 8'h2D);

        for (int i = 0; i < 6; i++) begin
            serve(4'($urandom_range(1, 15)), 8'($urandom_range(0, 255)),
                  $urandom_range(1, 3), 0, 0, 8'h00);
        end

        // Lockup: forced FF at CHECK restarts the LFSR, one step later it reads 01.
        do_reset();
        e.gnt  = 4'b0001;
        e.data = 8'h01;
        sb_q.push_back(e);
        model_last = 0;
        model_lfsr = 8'h01;
        req        = 4'b0001;
        range_max  = 8'hFF;
        repeat (9) @(negedge clk);
        check("check_no_en", lfsr_enable, 0);
        force_val = 8'hFF;
        force_en  = 1'b1;
        #1;
        check("lockup_rst", lfsr_reset, 1);
        check("lockup_no_gnt", gnt, 0);
        @(negedge clk);
        force_en = 1'b0;
        check("restep_en", lfsr_enable, 1);
        check("restep_rst", lfsr_reset, 0);
        @(negedge clk);
        check("recheck_no_valid", rnd_valid, 0);
        @(negedge clk);
        check("lockup_grant", rnd_valid, 1);
        req = '0;
        @(negedge clk);

        // Reset landing mid-draw.
        req       = 4'b1111;
        range_max = 8'h33;
        repeat (4) @(negedge clk);
        check("mid_step_en", lfsr_enable, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_gnt", gnt, 0);
        check("midrst_valid", rnd_valid, 0);
        check("midrst_data", rnd_data, 0);
        check("midrst_en", lfsr_enable, 0);
        check("midrst_lrst", lfsr_reset, 0);
        do_reset();
        serve(4'b1111, 8'hFF, 1, 0, 0, 8'h00);
        check("prio_after_rst", last_data, 8'hF0);

        check("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
